ones_count_accum: RTL

Parametrised, registered successor to the 7-input combinational ones counter. Each cycle it accepts an N-bit sample, outputs the registered count of set bits, and accumulates those counts over a frame delimited by `in_last`. The block sits between a sample source and a statistics consumer, which receives one saturating frame total per frame.

---
 rtl/ones_pkg.sv | 18 +
 rtl/ones_counter.sv | 12 +
 rtl/ones_count_accum.sv | 51 +++++
 3 files changed

// File: rtl/ones_pkg.sv
// ones_pkg: shared state type and arithmetic helpers for the ones-count accumulator
package ones_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [0:0] {IDLE, RUN} oc_state_t;
  function automatic logic [6:0] popcount(input logic [MAX_W-1:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < MAX_W; i++) c = c + 7'(d[i]);
    return c;
  endfunction
  // Returns {saturated, value}; value clamps to 2^w-1 when the w-bit sum overflows.
  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b, input int unsigned w);
    logic [MAX_W:0] sum, lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ({{MAX_W{1'b0}}, 1'b1} << w) - 1'b1;
    return (sum > lim) ? {1'b1, lim[MAX_W-1:0]} : {1'b0, sum[MAX_W-1:0]};
  endfunction
endpackage

// File: rtl/ones_counter.sv
// ones_counter: combinational popcount of an N-bit sample
module ones_counter import ones_pkg::*; #(
  parameter int N = 7,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  data,
  output logic [CW-1:0] cnt
);
  logic [6:0] full;
  always_comb full = popcount(MAX_W'(data));
  assign cnt = full[CW-1:0];
endmodule

// File: rtl/ones_count_accum.sv
// ones_count_accum: registered per-sample popcount with saturating per-frame accumulation
module ones_count_accum import ones_pkg::*; #(
  parameter int N = 7,
  parameter int ACC_W = 12,
  localparam int CW = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  input  logic             clear,
  output logic             cnt_valid,
  output logic [CW-1:0]    cnt,
  output logic             acc_valid,
  output logic [ACC_W-1:0] acc,
  output logic             acc_sat,
  output logic             busy
);
  oc_state_t state;
  logic [CW-1:0] pc;
  logic [MAX_W:0] sum;
  ones_counter #(.N(N)) u_cnt (.data(in_data), .cnt(pc));
  always_comb sum = sat_add(MAX_W'(acc), MAX_W'(pc), ACC_W);
  assign busy = (state == RUN);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt_valid <= 1'b0;
      cnt       <= '0;
      acc_valid <= 1'b0;
      acc       <= '0;
      acc_sat   <= 1'b0;
    end else begin
      cnt_valid <= in_valid;
      if (in_valid) cnt <= pc;
      acc_valid <= 1'b0;
      // clear wins over a coincident sample, including one carrying in_last
      if (clear) begin
        acc     <= '0;
        acc_sat <= 1'b0;
        state   <= IDLE;
      end else if (in_valid) begin
        acc       <= (state == IDLE) ? ACC_W'(pc) : sum[ACC_W-1:0];
        acc_sat   <= (state == RUN) && (acc_sat || sum[MAX_W]);
        acc_valid <= in_last;
        state     <= in_last ? IDLE : RUN;
      end
    end
  end
endmodule
